// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversamples sck/ss/mosi in the clk domain, shifts one byte per
// eight sck rises, and reloads the transmit byte at every byte boundary.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] d,
  output logic       d_ack,
  output logic [7:0] q,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);

  state_t state;
  state_t state_next;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   ss_d;
  logic [2:0]             settle_cnt;
  logic                   settled;
  logic                   sck_s;
  logic                   ss_s;
  logic                   mosi_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   ss_rise;
  logic                   ss_fall;
  logic [7:0]             tx_shift;
  logic [7:0]             rx_shift;
  logic [2:0]             bit_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
    end
  end

  // Edges are masked until the chains have flushed after reset, so an ss already
  // low at release settles quietly instead of looking like a frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt <= 3'd0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + 3'd1;
    end
  end

  assign settled  = (settle_cnt == SETTLE);
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = settled &  sck_s & ~sck_d;
  assign sck_fall = settled & ~sck_s &  sck_d;
  assign ss_rise  = settled &  ss_s  & ~ss_d;
  assign ss_fall  = settled & ~ss_s  &  ss_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (ss_fall) state_next = ACTIVE;
      ACTIVE: if (ss_rise) state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ACTIVE);
    miso = (state == ACTIVE) ? tx_shift[7] : 1'bz;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift  <= 8'h00;
      rx_shift  <= 8'h00;
      bit_cnt   <= 3'd0;
      q         <= 8'h00;
      rx_valid  <= 1'b0;
      d_ack     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      d_ack     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            tx_shift <= d;
            bit_cnt  <= 3'd0;
            d_ack    <= 1'b1;
          end
        end
        ACTIVE: begin
          // ss rise wins over any sck edge seen in the same cycle.
          if (ss_rise) begin
            frame_err <= (bit_cnt != 3'd0);
            bit_cnt   <= 3'd0;
            rx_shift  <= 8'h00;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[6:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              q        <= {rx_shift[6:0], mosi_s};
              rx_valid <= 1'b1;
            end
          end else if (sck_fall) begin
            if (bit_cnt != 3'd0) begin
              tx_shift <= {tx_shift[6:0], 1'b0};
            end else begin
              tx_shift <= d;
              d_ack    <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
